// File: rtl/johnson_phase_decoder.sv
// johnson_phase_decoder
//   Decodes the 4-bit Johnson code from an upstream counter into a phase
//   index. It checks that successive samples advance legally, locks after
//   LOCK_COUNT consecutive advances, and counts completed 8-phase cycles
//   while locked.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   en            sample qualifier; jc_in is evaluated only when en=1
//   jc_in[3:0]    Johnson code from the upstream counter
//   clr_err       synchronous clear of seq_err (a coincident new fault wins)
//   phase[2:0]    phase index of the last legal sample
//   phase_onehot  one-hot of phase while valid=1, otherwise zero
//   valid         the last evaluated sample was a legal code
//   locked        FSM is in LOCKED
//   seq_err       sticky flag for a sequence fault seen while LOCKED
//   cycle_cnt     completed 8-phase cycles while LOCKED (wraps)
//   wrap_pulse    one-cycle strobe on a LOCKED phase 7 -> 0 advance
module johnson_phase_decoder #(
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [3:0]       jc_in,
    input  logic             clr_err,
    output logic [2:0]       phase,
    output logic [7:0]       phase_onehot,
    output logic             valid,
    output logic             locked,
    output logic             seq_err,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic             wrap_pulse
);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        LOCKED = 2'd1,
        ERROR  = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);

    state_t     state, state_nxt;
    logic [3:0] step, step_nxt;
    logic [3:0] prev, prev_nxt;
    logic       prev_ok, prev_ok_nxt;
    logic       code_legal;
    logic [2:0] code_phase;
    logic       advance;
    logic       fault;
    logic       wrap;

    always_comb begin
        code_legal = 1'b1;
        code_phase = 3'd0;
        case (jc_in)
            4'b0000: code_phase = 3'd0;
            4'b0001: code_phase = 3'd1;
            4'b0011: code_phase = 3'd2;
            4'b0111: code_phase = 3'd3;
            4'b1111: code_phase = 3'd4;
            4'b1110: code_phase = 3'd5;
            4'b1100: code_phase = 3'd6;
            4'b1000: code_phase = 3'd7;
            default: code_legal = 1'b0;
        endcase
    end

    // The next Johnson code shifts left and feeds back the inverted MSB.
    // A repeated code therefore never counts as an advance.
    assign advance = code_legal && prev_ok && (jc_in == {prev[2:0], ~prev[3]});

    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        prev_nxt    = prev;
        prev_ok_nxt = prev_ok;
        fault       = 1'b0;
        wrap        = 1'b0;
        if (en) begin
            if (code_legal) begin
                prev_nxt    = jc_in;
                prev_ok_nxt = 1'b1;
            end
            case (state)
                SEARCH: begin
                    if (advance) begin
                        if (step + 4'd1 >= LOCK_N) begin
                            state_nxt = LOCKED;
                            step_nxt  = '0;
                        end else begin
                            step_nxt = step + 4'd1;
                        end
                    end else if (code_legal) begin
                        // The first code after reset only seeds prev.
                        // A legal bad step restarts the count at 1.
                        step_nxt = prev_ok ? 4'd1 : 4'd0;
                    end else begin
                        step_nxt = '0;
                    end
                end
                LOCKED: begin
                    if (advance) begin
                        wrap = (prev == 4'b1000);
                    end else begin
                        state_nxt = ERROR;
                        fault     = 1'b1;
                    end
                end
                ERROR: begin
                    if (code_legal) begin
                        state_nxt = SEARCH;
                        step_nxt  = '0;
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= SEARCH;
            step         <= '0;
            prev         <= '0;
            prev_ok      <= 1'b0;
            phase        <= '0;
            phase_onehot <= '0;
            valid        <= 1'b0;
            locked       <= 1'b0;
            seq_err      <= 1'b0;
            cycle_cnt    <= '0;
            wrap_pulse   <= 1'b0;
        end else begin
            state      <= state_nxt;
            step       <= step_nxt;
            prev       <= prev_nxt;
            prev_ok    <= prev_ok_nxt;
            locked     <= (state_nxt == LOCKED);
            wrap_pulse <= wrap;
            if (en) begin
                valid        <= code_legal;
                phase_onehot <= code_legal ? (8'b1 << code_phase) : '0;
                if (code_legal) begin
                    phase <= code_phase;
                end
            end
            if (wrap) begin
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            end
            if (fault) begin
                seq_err <= 1'b1;
            end else if (clr_err) begin
                seq_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// tb_johnson_phase_decoder
//   Directed tests for johnson_phase_decoder. DUT "a" uses the default
//   parameters. DUT "b" uses CNT_W=2 to exercise counter wrap and
//   asynchronous reset.
module tb_johnson_phase_decoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst, a_en, a_clr;
    logic [3:0] a_jc;
    logic [2:0] a_phase;
    logic [7:0] a_oh;
    logic       a_valid, a_locked, a_seq_err, a_wrap;
    logic [7:0] a_cnt;

    logic       b_rst, b_en, b_clr;
    logic [3:0] b_jc;
    logic [2:0] b_phase;
    logic [7:0] b_oh;
    logic       b_valid, b_locked, b_seq_err, b_wrap;
    logic [1:0] b_cnt;

    int total = 0;
    int bad   = 0;

    // Packed status: {phase[2:0], valid, locked, seq_err, wrap_pulse}
    logic [6:0] a_st, b_st;
    assign a_st = {a_phase, a_valid, a_locked, a_seq_err, a_wrap};
    assign b_st = {b_phase, b_valid, b_locked, b_seq_err, b_wrap};

    johnson_phase_decoder #(.LOCK_COUNT(4), .CNT_W(8)) dut_a (
        .clk(clk), .reset(a_rst), .en(a_en), .jc_in(a_jc), .clr_err(a_clr),
        .phase(a_phase), .phase_onehot(a_oh), .valid(a_valid), .locked(a_locked),
        .seq_err(a_seq_err), .cycle_cnt(a_cnt), .wrap_pulse(a_wrap)
    );

    johnson_phase_decoder #(.LOCK_COUNT(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset(b_rst), .en(b_en), .jc_in(b_jc), .clr_err(b_clr),
        .phase(b_phase), .phase_onehot(b_oh), .valid(b_valid), .locked(b_locked),
        .seq_err(b_seq_err), .cycle_cnt(b_cnt), .wrap_pulse(b_wrap)
    );

    task automatic apply_a(input logic [3:0] code, input logic e, input logic c);
        @(negedge clk);
        a_jc = code; a_en = e; a_clr = c;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_b(input logic [3:0] code, input logic e);
        @(negedge clk);
        b_jc = code; b_en = e; b_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        a_rst = 1'b0; a_en = 1'b0; a_clr = 1'b0; a_jc = 4'b0000;
        b_rst = 1'b0; b_en = 1'b0; b_clr = 1'b0; b_jc = 4'b0000;
        #1;
        total++; if (a_st !== 7'b0) begin bad++; $display("FAIL reset_status got=%b want=%b", a_st, 7'b0); end
        total++; if (a_oh !== 8'h00) begin bad++; $display("FAIL reset_onehot got=%h want=%h", a_oh, 8'h00); end
        total++; if (a_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d want=0", a_cnt); end
        @(negedge clk); @(negedge clk);
        a_rst = 1'b1; b_rst = 1'b1;
    endtask

    task automatic test_lock;
        apply_a(4'b0001, 1'b1, 1'b0);
        total++; if (a_st !== {3'd1, 4'b1000}) begin bad++; $display("FAIL lock_s1 got=%b want=%b", a_st, {3'd1, 4'b1000}); end
        apply_a(4'b0011, 1'b1, 1'b0);
        total++; if (a_st !== {3'd2, 4'b1000}) begin bad++; $display("FAIL lock_s2 got=%b want=%b", a_st, {3'd2, 4'b1000}); end
        apply_a(4'b0111, 1'b1, 1'b0);
        total++; if (a_st !== {3'd3, 4'b1000}) begin bad++; $display("FAIL lock_s3 got=%b want=%b", a_st, {3'd3, 4'b1000}); end
        apply_a(4'b1111, 1'b1, 1'b0);
        total++; if (a_st !== {3'd4, 4'b1000}) begin bad++; $display("FAIL lock_s4 got=%b want=%b", a_st, {3'd4, 4'b1000}); end
        apply_a(4'b1110, 1'b1, 1'b0);
        total++; if (a_st !== {3'd5, 4'b1100}) begin bad++; $display("FAIL lock_s5 got=%b want=%b", a_st, {3'd5, 4'b1100}); end
        total++; if (a_oh !== 8'h20) begin bad++; $display("FAIL lock_onehot got=%h want=%h", a_oh, 8'h20); end
    endtask

    task automatic test_wrap;
        apply_a(4'b1100, 1'b1, 1'b0);
        total++; if (a_st !== {3'd6, 4'b1100}) begin bad++; $display("FAIL wrap_p6 got=%b want=%b", a_st, {3'd6, 4'b1100}); end
        apply_a(4'b1000, 1'b1, 1'b0);
        total++; if (a_st !== {3'd7, 4'b1100}) begin bad++; $display("FAIL wrap_p7 got=%b want=%b", a_st, {3'd7, 4'b1100}); end
        total++; if (a_cnt !== 8'd0) begin bad++; $display("FAIL wrap_cnt_before got=%0d want=0", a_cnt); end
        apply_a(4'b0000, 1'b1, 1'b0);
        total++; if (a_st !== {3'd0, 4'b1101}) begin bad++; $display("FAIL wrap_p0 got=%b want=%b", a_st, {3'd0, 4'b1101}); end
        total++; if (a_cnt !== 8'd1) begin bad++; $display("FAIL wrap_cnt got=%0d want=1", a_cnt); end
        total++; if (a_oh !== 8'h01) begin bad++; $display("FAIL wrap_onehot got=%h want=%h", a_oh, 8'h01); end
        apply_a(4'b0001, 1'b1, 1'b0);
        total++; if (a_st !== {3'd1, 4'b1100}) begin bad++; $display("FAIL wrap_after got=%b want=%b", a_st, {3'd1, 4'b1100}); end
        total++; if (a_cnt !== 8'd1) begin bad++; $display("FAIL wrap_cnt_hold got=%0d want=1", a_cnt); end
    endtask

    task automatic test_en_hold;
        apply_a(4'b0011, 1'b1, 1'b0);
        total++; if (a_st !== {3'd2, 4'b1100}) begin bad++; $display("FAIL en_adv got=%b want=%b", a_st, {3'd2, 4'b1100}); end
        apply_a(4'b0011, 1'b0, 1'b0);
        total++; if (a_st !== {3'd2, 4'b1100}) begin bad++; $display("FAIL en0_repeat got=%b want=%b", a_st, {3'd2, 4'b1100}); end
        apply_a(4'b0101, 1'b0, 1'b0);
        total++; if (a_st !== {3'd2, 4'b1100}) begin bad++; $display("FAIL en0_illegal got=%b want=%b", a_st, {3'd2, 4'b1100}); end
        apply_a(4'b0011, 1'b1, 1'b0);
        total++; if (a_st !== {3'd2, 4'b1010}) begin bad++; $display("FAIL repeat_fault got=%b want=%b", a_st, {3'd2, 4'b1010}); end
    endtask

    task automatic test_clr;
        apply_a(4'b0111, 1'b1, 1'b1);
        total++; if (a_st !== {3'd3, 4'b1000}) begin bad++; $display("FAIL clr_no_fault got=%b want=%b", a_st, {3'd3, 4'b1000}); end
    endtask

    task automatic test_fault_recovery;
        apply_a(4'b1111, 1'b1, 1'b0);
        apply_a(4'b1110, 1'b1, 1'b0);
        apply_a(4'b1100, 1'b1, 1'b0);
        total++; if (a_st !== {3'd6, 4'b1000}) begin bad++; $display("FAIL relock_pre got=%b want=%b", a_st, {3'd6, 4'b1000}); end
        apply_a(4'b1000, 1'b1, 1'b0);
        total++; if (a_st !== {3'd7, 4'b1100}) begin bad++; $display("FAIL relock got=%b want=%b", a_st, {3'd7, 4'b1100}); end
        apply_a(4'b0000, 1'b1, 1'b0);
        total++; if (a_cnt !== 8'd2) begin bad++; $display("FAIL relock_cnt got=%0d want=2", a_cnt); end
        apply_a(4'b0001, 1'b1, 1'b0);
        apply_a(4'b0011, 1'b1, 1'b0);
        apply_a(4'b0111, 1'b1, 1'b0);
        total++; if (a_st !== {3'd3, 4'b1100}) begin bad++; $display("FAIL at_p3 got=%b want=%b", a_st, {3'd3, 4'b1100}); end
        apply_a(4'b0101, 1'b1, 1'b0);
        total++; if (a_st !== {3'd3, 4'b0010}) begin bad++; $display("FAIL illegal_fault got=%b want=%b", a_st, {3'd3, 4'b0010}); end
        total++; if (a_oh !== 8'h00) begin bad++; $display("FAIL illegal_onehot got=%h want=%h", a_oh, 8'h00); end
        apply_a(4'b0001, 1'b1, 1'b0);
        total++; if (a_st !== {3'd1, 4'b1010}) begin bad++; $display("FAIL err_exit got=%b want=%b", a_st, {3'd1, 4'b1010}); end
        total++; if (a_cnt !== 8'd2) begin bad++; $display("FAIL cnt_hold_err got=%0d want=2", a_cnt); end
    endtask

    task automatic test_clr_vs_fault;
        apply_a(4'b0011, 1'b1, 1'b1);
        total++; if (a_st !== {3'd2, 4'b1000}) begin bad++; $display("FAIL clr_search got=%b want=%b", a_st, {3'd2, 4'b1000}); end
        apply_a(4'b0111, 1'b1, 1'b0);
        apply_a(4'b1111, 1'b1, 1'b0);
        apply_a(4'b1110, 1'b1, 1'b0);
        total++; if (a_st !== {3'd5, 4'b1100}) begin bad++; $display("FAIL relock2 got=%b want=%b", a_st, {3'd5, 4'b1100}); end
        apply_a(4'b1010, 1'b1, 1'b1);
        total++; if (a_st !== {3'd5, 4'b0010}) begin bad++; $display("FAIL set_wins got=%b want=%b", a_st, {3'd5, 4'b0010}); end
        apply_a(4'b0001, 1'b1, 1'b1);
        total++; if (a_st !== {3'd1, 4'b1000}) begin bad++; $display("FAIL clr_after got=%b want=%b", a_st, {3'd1, 4'b1000}); end
    endtask

    task automatic test_cnt_wrap;
        logic [3:0] cyc [8];
        logic [1:0] want_cnt [4];
        cyc = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        want_cnt = '{2'd1, 2'd2, 2'd3, 2'd0};
        apply_b(4'b0000, 1'b1);
        total++; if (b_st !== {3'd0, 4'b1000}) begin bad++; $display("FAIL b_first got=%b want=%b", b_st, {3'd0, 4'b1000}); end
        for (int i = 0; i < 4; i++) apply_b(cyc[i], 1'b1);
        total++; if (b_st !== {3'd4, 4'b1100}) begin bad++; $display("FAIL b_lock got=%b want=%b", b_st, {3'd4, 4'b1100}); end
        for (int i = 4; i < 7; i++) apply_b(cyc[i], 1'b1);
        for (int k = 0; k < 4; k++) begin
            apply_b(4'b0000, 1'b1);
            total++; if (b_wrap !== 1'b1) begin bad++; $display("FAIL b_wrap%0d got=%b want=1", k, b_wrap); end
            total++; if (b_cnt !== want_cnt[k]) begin bad++; $display("FAIL b_cnt%0d got=%0d want=%0d", k, b_cnt, want_cnt[k]); end
            if (k < 3) begin
                for (int i = 0; i < 7; i++) apply_b(cyc[i], 1'b1);
                total++; if (b_wrap !== 1'b0) begin bad++; $display("FAIL b_nowrap%0d got=%b want=0", k, b_wrap); end
            end
        end
        for (int i = 0; i < 8; i++) apply_b(cyc[i], 1'b1);
        total++; if (b_cnt !== 2'd1) begin bad++; $display("FAIL b_cnt_again got=%0d want=1", b_cnt); end
    endtask

    task automatic test_async_reset;
        apply_b(4'b0001, 1'b1);
        apply_b(4'b0011, 1'b1);
        total++; if (b_st !== {3'd2, 4'b1100}) begin bad++; $display("FAIL b_pre_rst got=%b want=%b", b_st, {3'd2, 4'b1100}); end
        #2;
        b_rst = 1'b0;
        #1;
        total++; if (b_st !== 7'b0) begin bad++; $display("FAIL b_async_st got=%b want=%b", b_st, 7'b0); end
        total++; if (b_cnt !== 2'd0) begin bad++; $display("FAIL b_async_cnt got=%0d want=0", b_cnt); end
        total++; if (b_oh !== 8'h00) begin bad++; $display("FAIL b_async_oh got=%h want=00", b_oh); end
        @(negedge clk);
        b_rst = 1'b1;
        apply_b(4'b0011, 1'b1);
        total++; if (b_st !== {3'd2, 4'b1000}) begin bad++; $display("FAIL b_fresh got=%b want=%b", b_st, {3'd2, 4'b1000}); end
        total++; if (b_oh !== 8'h04) begin bad++; $display("FAIL b_fresh_oh got=%h want=04", b_oh); end
    endtask

    initial begin
        test_reset;
        test_lock;
        test_wrap;
        test_en_hold;
        test_clr;
        test_fault_recovery;
        test_clr_vs_fault;
        test_cnt_wrap;
        test_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/johnson_phase_decoder.md
JOHNSON_PHASE_DECODER -- requirements
Module: johnson_phase_decoder

Interface
REQ-001 Parameter LOCK_COUNT, default 4, is the number of consecutive legal advances needed to enter LOCKED (range 1..15).
REQ-002 Parameter CNT_W, default 8, is the width of the completed-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; the block is in reset while low.
REQ-005 en  input  1  sample qualifier; jc_in is evaluated only on cycles with en=1.
REQ-006 jc_in  input  4  Johnson code from the upstream 4-bit Johnson counter.
REQ-007 clr_err  input  1  synchronous clear of the sticky seq_err flag.
REQ-008 phase  output  3  registered phase index of the last legal sample.
REQ-009 phase_onehot  output  8  registered one-hot of phase; bit[phase] set when valid=1, else all zero.
REQ-010 valid  output  1  last evaluated sample was a legal code.
REQ-011 locked  output  1  high while the FSM is in LOCKED.
REQ-012 seq_err  output  1  sticky error: a sequence fault occurred while LOCKED.
REQ-013 cycle_cnt  output  CNT_W  count of completed 8-phase cycles while LOCKED.
REQ-014 wrap_pulse  output  1  one-cycle strobe when a phase-7 to phase-0 advance occurs while LOCKED.

Function
REQ-015 Legal code map SHALL be: 0000->0, 0001->1, 0011->2, 0111->3, 1111->4, 1110->5, 1100->6, 1000->7; all other 8 codes are illegal.
REQ-016 A legal advance SHALL be a sample equal to {prev[2:0], ~prev[3]}, where prev is the last legal sample; a repeated code with en=1 is a bad step.
REQ-017 All outputs SHALL be registered; the response to a sample appears one clk after the edge on which en=1 and jc_in are captured.
REQ-018 With en=0, phase, valid, FSM state, step counter, cycle_cnt and seq_err SHALL hold; wrap_pulse SHALL be 0.
REQ-019 FSM states SHALL be SEARCH, LOCKED, ERROR.
REQ-020 SEARCH: legal advance increments step counter; reaching LOCK_COUNT moves to LOCKED; illegal code or bad step sets step counter to 0 (to 1 if the code itself is legal, used as new prev).
REQ-021 LOCKED: legal advance stays LOCKED; illegal code or bad step moves to ERROR and sets seq_err.
REQ-022 ERROR: locked=0; first legal code moves to SEARCH with step counter 0 and that code as prev; illegal codes stay in ERROR.
REQ-023 valid SHALL follow each evaluated sample's legality in every state; phase holds its last legal value on illegal samples.
REQ-024 cycle_cnt SHALL increment by 1 only on a LOCKED legal advance from phase 7 to phase 0, wrapping from 2^CNT_W-1 to 0; wrap_pulse fires on the same cycle.
REQ-025 cycle_cnt SHALL hold (not clear) on leaving LOCKED.
REQ-026 clr_err=1 SHALL clear seq_err; if a new fault sets seq_err in the same cycle, set wins.

Reset
REQ-027 While reset=0: state=SEARCH, step counter=0, phase=0, phase_onehot=0, valid=0, locked=0, seq_err=0, cycle_cnt=0, wrap_pulse=0, prev invalid.
REQ-028 Reset assertion mid-operation SHALL take effect immediately without waiting for clk; first sample after release is treated as a fresh first legal/illegal code.

Verification
REQ-029 Release reset, en=1, jc_in follows 0001,0011,0111,1111,1110 -> valid=1 from first sample, phase 1..5, locked=1 one clk after 1110 is captured (4 advances).
REQ-030 Locked, stream runs 1000,0000,0001 -> wrap_pulse=1 exactly once after 0000 captured, cycle_cnt 0->1.
REQ-031 Locked at phase 3 (0111), inject 0101 -> valid=0, locked=0, seq_err=1, phase stays 3; then 0001 -> state SEARCH, valid=1, phase=1.
REQ-032 Locked at 0011, repeat 0011 with en=1 -> ERROR, seq_err=1; same stimulus with en=0 -> no change.
REQ-033 seq_err=1, assert clr_err for one cycle with no fault -> seq_err=0; clr_err coincident with a new fault -> seq_err stays 1.
REQ-034 CNT_W=2, run 4 full cycles locked -> cycle_cnt 1,2,3,0 with wrap_pulse each time; pull reset low mid-cycle -> all outputs zero asynchronously.
